feature_fetch_engine: RTL and testbench
=======================================

Name: feature_fetch_engine

Overview:
- Parametrised burst fetch engine that moves feature data from external memory into the ping-pong on-chip feature_in buffers.
- Takes one command (source address, destination address, beat count, buffer select) through a valid/ready handshake.
- Issues a stream of read requests and accepts in-order read data with backpressure.
- Unpacks each EXT_DW beat into EXT_DW/BUF_DW buffer words and writes them to consecutive destination addresses, then pulses done.
- Sits between the instruction parser/controller and the feature_in memory, as the multi-beat successor of the single-word feature fetch path.

Parameters:
- EXT_DW, 128, external read data width in bits; must be an integer multiple of BUF_DW.
- BUF_DW, 16, feature buffer word width.
- SRC_AW, 16, external beat address width.
- DST_AW, 15, feature buffer word address width.
- LEN_W, 8, width of the beat-count field.
- NUM_BUF, 2, number of selectable feature buffers.
- LANES is derived: EXT_DW/BUF_DW, 8 at defaults.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_src_addr  in  SRC_AW  first external beat address
- cmd_dst_addr  in  DST_AW  first buffer word address
- cmd_len  in  LEN_W  number of EXT_DW beats to fetch
- cmd_buf_sel  in  clog2(NUM_BUF)  target buffer
- mem_req  out  1  read request valid
- mem_req_ready  in  1  memory accepts request this cycle
- mem_req_addr  out  SRC_AW  request beat address
- mem_rd_valid  in  1  read data valid, returned in request order
- mem_rd_ready  out  1  engine accepts read data
- mem_rd_data  in  EXT_DW  read data
- wr_en  out  1  buffer write strobe
- wr_addr  out  DST_AW  buffer word address
- wr_data  out  BUF_DW  buffer word
- wr_buf_sel  out  clog2(NUM_BUF)  buffer select, held for the whole command
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters and holding register cleared; any in-flight command is abandoned.
- cmd_ready = 1 only in IDLE. A command is accepted on the cycle where cmd_valid && cmd_ready; all fields are latched at that edge.
- FSM states and transitions:
  - IDLE: on accept go to RUN, or to DONE if cmd_len == 0.
  - RUN: requests issued and data drained concurrently.
  - DRAIN: all requests issued; waiting for data and lane writes.
  - DONE: done = 1 for exactly one cycle, then back to IDLE.
- busy = 1 in RUN, DRAIN and DONE.
- Requests:
  - In RUN, mem_req = 1 while req_cnt < len. mem_req_addr = src + req_cnt, wrapping modulo 2^SRC_AW.
  - req_cnt increments on mem_req && mem_req_ready.
  - When the last request is accepted, go to DRAIN. That transition happens only if data is still pending, which it always is.
- Data path:
  - One EXT_DW holding register with a full flag.
  - mem_rd_ready = (RUN or DRAIN) && beat_cnt < len && (!full || (lane_cnt == LANES-1 && wr_en)).
  - A beat is accepted on mem_rd_valid && mem_rd_ready. It loads the holding register and increments beat_cnt.
  - mem_rd_valid outside RUN/DRAIN, or beyond len beats, is ignored.
- Unpack:
  - While full, wr_en = 1 every cycle. wr_data = lane lane_cnt, where lane 0 is bits [BUF_DW-1:0], emitted first.
  - wr_addr starts at dst and increments by 1 per write, wrapping modulo 2^DST_AW.
  - After lane LANES-1, full clears unless a new beat loads the register in the same cycle. Back-to-back beats therefore produce a continuous wr_en stream.
- Latency: the first wr_en is 1 cycle after the first accepted beat. wr_en, wr_addr, wr_data and wr_buf_sel are registered.
- Completion: in DRAIN, when beat_cnt == len && !full && !wr_en pending, go to DONE. done is asserted the cycle after the final lane write.
- cmd_valid while busy is not accepted and has no effect. The command must be held until accepted.
- Total writes per command = len*LANES. cmd_len == 0 produces no requests and no writes, and done pulses 1 cycle after accept.

Test Plan:
1. Single beat: src=0x0100, dst=0x0040, len=1, buf=1, mem_req_ready=1, data returned 3 cycles after request with value 0x0007_0006_..._0000 → one request at 0x0100; 8 writes at 0x0040..0x0047 with wr_data 0..7 and wr_buf_sel=1; done pulses once, the cycle after the 8th write.
2. Burst with streaming data: len=4, data returned every cycle → mem_rd_ready drops while the register is full and releases on lane 7; 32 contiguous writes at dst..dst+31; wr_en never gaps between beats once data is available.
3. Request and data backpressure: mem_req_ready toggled 1/0 and mem_rd_valid randomised, len=3 → exactly 3 requests at src, src+1, src+2 in order; 24 writes; no beat lost or duplicated.
4. Wrap: src=0xFFFF, dst=0x7FFC, len=2 → request addresses 0xFFFF, 0x0000; wr_addr runs 0x7FFC..0x7FFF, then 0x0000..0x000B.
5. Zero length and busy: len=0 → no mem_req, no wr_en, done 1 cycle after accept. A second cmd_valid asserted during a len=2 transfer is held off by cmd_ready=0 and accepted only after done.
6. Reset mid-burst: assert rst during the 10th write of a len=4 command → the next cycle all outputs are 0 and cmd_ready=1; a fresh len=1 command completes normally.

Source files
------------

// File: rtl/feature_fetch_engine_if.sv
// Command, external-read and feature-buffer-write bundle of the feature fetch engine.
// The master modport is the engine; the slave modport is its surroundings.
interface feature_fetch_engine_if #(
    parameter int unsigned EXT_DW  = 128,
    parameter int unsigned BUF_DW  = 16,
    parameter int unsigned SRC_AW  = 16,
    parameter int unsigned DST_AW  = 15,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned NUM_BUF = 2
);
    localparam int unsigned SelW = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [SRC_AW-1:0] cmd_src_addr;
    logic [DST_AW-1:0] cmd_dst_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [SelW-1:0]   cmd_buf_sel;

    logic              mem_req;
    logic              mem_req_ready;
    logic [SRC_AW-1:0] mem_req_addr;
    logic              mem_rd_valid;
    logic              mem_rd_ready;
    logic [EXT_DW-1:0] mem_rd_data;

    logic              wr_en;
    logic [DST_AW-1:0] wr_addr;
    logic [BUF_DW-1:0] wr_data;
    logic [SelW-1:0]   wr_buf_sel;

    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_len, cmd_buf_sel,
        output cmd_ready,
        output mem_req, mem_req_addr, mem_rd_ready,
        input  mem_req_ready, mem_rd_valid, mem_rd_data,
        output wr_en, wr_addr, wr_data, wr_buf_sel,
        output busy, done
    );

    modport slave (
        output cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_len, cmd_buf_sel,
        input  cmd_ready,
        input  mem_req, mem_req_addr, mem_rd_ready,
        output mem_req_ready, mem_rd_valid, mem_rd_data,
        input  wr_en, wr_addr, wr_data, wr_buf_sel,
        input  busy, done
    );
endinterface

// File: rtl/feature_fetch_engine.sv
// Burst fetch engine: reads len external beats and unpacks each into LANES consecutive
// feature-buffer word writes, lane 0 first, then pulses done.
module feature_fetch_engine #(
    parameter int unsigned EXT_DW  = 128,
    parameter int unsigned BUF_DW  = 16,
    parameter int unsigned SRC_AW  = 16,
    parameter int unsigned DST_AW  = 15,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned NUM_BUF = 2
) (
    input logic                    clk,
    input logic                    rst,
    feature_fetch_engine_if.master bus
);
    localparam int unsigned LANES = EXT_DW / BUF_DW;
    localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned SelW  = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [SRC_AW-1:0]             src_q, src_d;
    logic [LEN_W-1:0]              len_q, len_d;
    logic [SelW-1:0]               sel_q, sel_d;
    logic [LEN_W-1:0]              req_cnt_q, req_cnt_d;
    logic [LEN_W-1:0]              beat_cnt_q, beat_cnt_d;
    logic [LANES-1:0][BUF_DW-1:0]  hold_q, hold_d;
    logic                          full_q, full_d;
    logic [LaneW-1:0]              lane_cnt_q, lane_cnt_d;
    logic [DST_AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [DST_AW-1:0]             wr_addr_q, wr_addr_d;
    logic [BUF_DW-1:0]             wr_data_q, wr_data_d;

    logic cmd_ready, busy, done, mem_req, mem_rd_ready;
    logic cmd_fire, req_fire, beat_fire, lane_last;
    logic [LaneW-1:0] lane_nxt;

    // full_q doubles as the registered write strobe: a full register is always emitting a lane.
    assign lane_last = full_q && (lane_cnt_q == LaneW'(LANES - 1));
    assign lane_nxt  = lane_cnt_q + 1'b1;
    assign cmd_fire  = bus.cmd_valid && cmd_ready;
    assign req_fire  = mem_req && bus.mem_req_ready;
    assign beat_fire = bus.mem_rd_valid && mem_rd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_fire) state_d = (bus.cmd_len == '0) ? StDone : StRun;
            StRun:   if (req_fire && (req_cnt_q == len_q - 1'b1)) state_d = StDrain;
            StDrain: if ((beat_cnt_q == len_q) && (!full_q || lane_last)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        mem_req      = 1'b0;
        mem_rd_ready = 1'b0;
        unique case (state_q)
            StIdle: cmd_ready = 1'b1;
            StRun: begin
                busy         = 1'b1;
                mem_req      = (req_cnt_q < len_q);
                mem_rd_ready = (beat_cnt_q < len_q) && (!full_q || lane_last);
            end
            StDrain: begin
                busy         = 1'b1;
                mem_rd_ready = (beat_cnt_q < len_q) && (!full_q || lane_last);
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        src_d      = src_q;
        len_d      = len_q;
        sel_d      = sel_q;
        req_cnt_d  = req_cnt_q;
        beat_cnt_d = beat_cnt_q;
        hold_d     = hold_q;
        full_d     = full_q;
        lane_cnt_d = lane_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (cmd_fire) begin
            src_d      = bus.cmd_src_addr;
            len_d      = bus.cmd_len;
            sel_d      = bus.cmd_buf_sel;
            wr_ptr_d   = bus.cmd_dst_addr;
            req_cnt_d  = '0;
            beat_cnt_d = '0;
        end

        if (req_fire) begin
            req_cnt_d = req_cnt_q + 1'b1;
        end

        // A new beat may land on the last-lane cycle, keeping the write stream gap-free.
        if (beat_fire) begin
            hold_d     = bus.mem_rd_data;
            full_d     = 1'b1;
            lane_cnt_d = '0;
            wr_data_d  = bus.mem_rd_data[BUF_DW-1:0];
            wr_addr_d  = wr_ptr_q;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            beat_cnt_d = beat_cnt_q + 1'b1;
        end else if (full_q) begin
            if (lane_last) begin
                full_d = 1'b0;
            end else begin
                lane_cnt_d = lane_nxt;
                wr_data_d  = hold_q[lane_nxt];
                wr_addr_d  = wr_ptr_q;
                wr_ptr_d   = wr_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q      <= '0;
            len_q      <= '0;
            sel_q      <= '0;
            req_cnt_q  <= '0;
            beat_cnt_q <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            lane_cnt_q <= '0;
            wr_ptr_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            src_q      <= src_d;
            len_q      <= len_d;
            sel_q      <= sel_d;
            req_cnt_q  <= req_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            lane_cnt_q <= lane_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign bus.cmd_ready    = cmd_ready;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.mem_req      = mem_req;
    assign bus.mem_req_addr = src_q + SRC_AW'(req_cnt_q);
    assign bus.mem_rd_ready = mem_rd_ready;
    assign bus.wr_en        = full_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.wr_buf_sel   = sel_q;
endmodule

// File: tb/tb_feature_fetch_engine.sv
// Directed bench for feature_fetch_engine: table of commands against a latency-configurable
// memory responder, plus hand-written busy and mid-burst reset sequences.
module tb_feature_fetch_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    feature_fetch_engine_if bus ();
    feature_fetch_engine dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [15:0] addr;
        int          rdy;
    } pend_t;

    typedef struct {
        logic [15:0] src;
        logic [14:0] dst;
        logic [7:0]  len;
        logic        sel;
        int          lat;
        bit          tog;
        bit          rnd;
        bit          contig;
        int          exp_req;
        logic [15:0] exp_first_req;
        logic [15:0] exp_last_req;
        int          exp_wr;
        logic [14:0] exp_last_wa;
        logic [15:0] exp_last_wd;
    } vec_t;

    localparam logic [63:0] ResetOuts = 64'h0020_0000_0000_0000;

    pend_t       pend[$];
    logic [15:0] req_log[$];
    logic [14:0] wa_log[$];
    logic [15:0] wd_log[$];
    logic        ws_log[$];
    int cyc, checks, failures;
    int lat;
    bit req_toggle, rd_rand;
    int first_wr_cyc, last_wr_cyc, first_beat_cyc, done_cnt, done_cyc;
    int acc_cnt, acc_cyc, bad_rdy, rdy_full_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] beat_data(input logic [15:0] addr);
        logic [127:0] d;
        for (int l = 0; l < 8; l++) d[l*16 +: 16] = {addr[7:0], 8'(l)};
        return d;
    endfunction

    function automatic logic [63:0] outs();
        return {10'd0, bus.cmd_ready, bus.mem_req, bus.mem_req_addr, bus.mem_rd_ready, bus.wr_en,
                bus.wr_addr, bus.wr_data, bus.wr_buf_sel, bus.busy, bus.done};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        req_log.delete();
        wa_log.delete();
        wd_log.delete();
        ws_log.delete();
        first_wr_cyc = -1;
        last_wr_cyc = -1;
        first_beat_cyc = -1;
        done_cnt = 0;
        done_cyc = -1;
        acc_cnt = 0;
        acc_cyc = -1;
        bad_rdy = 0;
        rdy_full_cnt = 0;
    endtask

    // Memory responder and output monitor: sample at negedge, drive just after posedge.
    initial begin
        bus.mem_req_ready = 1'b0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend.delete();
            end else begin
                if (bus.mem_rd_valid && bus.mem_rd_ready) begin
                    pend.delete(0);
                    if (first_beat_cyc < 0) first_beat_cyc = cyc;
                end
                if (bus.mem_req && bus.mem_req_ready) begin
                    req_log.push_back(bus.mem_req_addr);
                    pend.push_back('{addr: bus.mem_req_addr, rdy: cyc + 1 + lat});
                end
                if (bus.wr_en) begin
                    wa_log.push_back(bus.wr_addr);
                    wd_log.push_back(bus.wr_data);
                    ws_log.push_back(bus.wr_buf_sel);
                    if (first_wr_cyc < 0) first_wr_cyc = cyc;
                    last_wr_cyc = cyc;
                    if (bus.mem_rd_ready) rdy_full_cnt++;
                end
                if (bus.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (bus.cmd_valid && bus.cmd_ready) begin
                    acc_cnt++;
                    acc_cyc = cyc;
                end
                if (bus.busy && bus.cmd_ready) bad_rdy++;
            end
            @(posedge clk);
            #1;
            bus.mem_req_ready = req_toggle ? !bus.mem_req_ready : 1'b1;
            if (pend.size() > 0 && pend[0].rdy <= cyc && (!rd_rand || $urandom_range(1, 0) == 1)) begin
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_data = beat_data(pend[0].addr);
            end else begin
                bus.mem_rd_valid = 1'b0;
                bus.mem_rd_data = '0;
            end
        end
    end

    task automatic issue(input logic [15:0] s, input logic [14:0] d, input logic [7:0] l,
                         input logic sel);
        int a0 = acc_cnt;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_src_addr = s;
        bus.cmd_dst_addr = d;
        bus.cmd_len = l;
        bus.cmd_buf_sel = sel;
        for (int t = 0; t < 50 && acc_cnt == a0; t++) @(posedge clk);
        chk("cmd_accept", 64'(acc_cnt - a0), 64'd1);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int n0);
        for (int t = 0; t < 3000 && done_cnt <= n0; t++) @(posedge clk);
        chk("done_seen", 64'(done_cnt > n0), 64'd1);
    endtask

    function automatic int stream_errs(input vec_t v);
        int errs = 0;
        for (int k = 0; k < wa_log.size(); k++) begin
            logic [15:0] ba = v.src + 16'(k / 8);
            if (wa_log[k] !== 15'(v.dst + 15'(k)) || wd_log[k] !== {ba[7:0], 8'(k % 8)}
                || ws_log[k] !== v.sel) errs++;
        end
        return errs;
    endfunction

    task automatic run_vec(input vec_t v);
        lat = v.lat;
        req_toggle = v.tog;
        rd_rand = v.rnd;
        clear_logs();
        issue(v.src, v.dst, v.len, v.sel);
        wait_done(0);
        repeat (2) @(posedge clk);
        chk("req_count", 64'(req_log.size()), 64'(v.exp_req));
        if (v.exp_req > 0) begin
            chk("first_req_addr", 64'(req_log[0]), 64'(v.exp_first_req));
            chk("last_req_addr", 64'(req_log[$]), 64'(v.exp_last_req));
        end
        chk("wr_count", 64'(wa_log.size()), 64'(v.exp_wr));
        if (v.exp_wr > 0) begin
            chk("last_wr_addr", 64'(wa_log[$]), 64'(v.exp_last_wa));
            chk("last_wr_data", 64'(wd_log[$]), 64'(v.exp_last_wd));
            chk("first_wr_latency", 64'(first_wr_cyc), 64'(first_beat_cyc + 1));
            chk("done_after_last_wr", 64'(done_cyc), 64'(last_wr_cyc + 1));
            if (v.contig) chk("wr_contiguous", 64'(last_wr_cyc - first_wr_cyc + 1), 64'(v.exp_wr));
        end else begin
            chk("done_after_accept", 64'(done_cyc), 64'(acc_cyc + 1));
        end
        chk("rd_ready_while_full", 64'(rdy_full_cnt), 64'((v.len > 0) ? v.len - 1 : 0));
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("wr_stream_errs", 64'(stream_errs(v)), 64'd0);
        chk("idle_after_done", {62'd0, bus.busy, bus.cmd_ready}, 64'd1);
    endtask

    initial begin
        vec_t vecs[5];
        vec_t fresh;
        vecs[0] = '{16'h0100, 15'h0040, 8'd1, 1'b1, 3, 0, 0, 1, 1, 16'h0100, 16'h0100, 8,
                    15'h0047, 16'h0007};
        vecs[1] = '{16'h0200, 15'h0100, 8'd4, 1'b0, 2, 0, 0, 1, 4, 16'h0200, 16'h0203, 32,
                    15'h011F, 16'h0307};
        vecs[2] = '{16'h0300, 15'h0200, 8'd3, 1'b1, 3, 1, 1, 0, 3, 16'h0300, 16'h0302, 24,
                    15'h0217, 16'h0207};
        vecs[3] = '{16'hFFFF, 15'h7FFC, 8'd2, 1'b0, 1, 0, 0, 1, 2, 16'hFFFF, 16'h0000, 16,
                    15'h000B, 16'h0007};
        vecs[4] = '{16'h0400, 15'h0010, 8'd0, 1'b1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0,
                    15'h0000, 16'h0000};
        fresh   = '{16'h0900, 15'h0700, 8'd1, 1'b0, 2, 0, 0, 1, 1, 16'h0900, 16'h0900, 8,
                    15'h0707, 16'h0007};

        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_src_addr = '0;
        bus.cmd_dst_addr = '0;
        bus.cmd_len = '0;
        bus.cmd_buf_sel = '0;
        lat = 1;
        req_toggle = 1'b0;
        rd_rand = 1'b0;
        clear_logs();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", outs(), ResetOuts);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // A second command held during a transfer is accepted only once done has pulsed.
        lat = 2;
        req_toggle = 1'b0;
        rd_rand = 1'b0;
        clear_logs();
        issue(16'h0600, 15'h0400, 8'd2, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_src_addr = 16'h0700;
        bus.cmd_dst_addr = 15'h0500;
        bus.cmd_len = 8'd1;
        bus.cmd_buf_sel = 1'b1;
        wait_done(0);
        chk("busy_held_off", 64'(acc_cnt), 64'd1);
        for (int t = 0; t < 20 && acc_cnt < 2; t++) @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        chk("busy_accept_after_done", 64'(acc_cyc), 64'(done_cyc + 1));
        wait_done(1);
        repeat (2) @(posedge clk);
        chk("busy_req_count", 64'(req_log.size()), 64'd3);
        chk("busy_last_req", 64'(req_log[$]), 64'h0700);
        chk("busy_wr_count", 64'(wa_log.size()), 64'd24);
        chk("busy_last_wr_addr", 64'(wa_log[$]), 64'h0507);
        chk("busy_cmd_ready_low", 64'(bad_rdy), 64'd0);

        // Reset lands during the 10th write of a 4-beat burst.
        lat = 1;
        clear_logs();
        issue(16'h0800, 15'h0600, 8'd4, 1'b1);
        for (int t = 0; t < 200 && !(bus.wr_en && wa_log.size() == 9); t++) begin
            @(posedge clk);
            #2;
        end
        chk("tenth_write_reached", {63'd0, bus.wr_en}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("reset_mid_burst_outputs", outs(), ResetOuts);
        rst = 1'b0;
        run_vec(fresh);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
